// File: rtl/armleocpu_decode.sv
// armleocpu_decode: decode stage between fetch and execute.
// Registers the fetch bundle, classifies the opcode, extracts register
// indices and the sign-extended immediate, and flags illegal encodings.
// Optional statistics counters are built when ARMLEOCPU_DECODE_STATS_EN
// is defined.
module armleocpu_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] f2e_instr,
    input  logic [31:0] f2e_pc,
    input  logic        f2e_exc_start,
    input  logic [31:0] f2e_epc,
    input  logic [31:0] f2e_cause,
    input  logic [1:0]  f2e_exc_privilege,
    output logic        e2f_ready,
    input  logic        x2d_ready,
    input  logic        x2d_kill,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    output logic        d2e_valid,
    output logic [31:0] d2e_instr,
    output logic [31:0] d2e_pc,
    output logic [3:0]  d2e_opclass,
    output logic [4:0]  d2e_rd,
    output logic [4:0]  d2e_rs1,
    output logic [4:0]  d2e_rs2,
    output logic [31:0] d2e_imm,
    output logic        d2e_illegal,
    output logic        d2e_exc_start,
    output logic [31:0] d2e_epc,
    output logic [31:0] d2e_cause,
    output logic [1:0]  d2e_exc_privilege
`ifdef ARMLEOCPU_DECODE_STATS_EN
    ,
    output logic [31:0] stat_decoded,
    output logic [31:0] stat_bubbles,
    output logic [31:0] stat_illegal
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] OC_BUBBLE  = 4'd0;
    localparam logic [3:0] OC_LUI     = 4'd1;
    localparam logic [3:0] OC_AUIPC   = 4'd2;
    localparam logic [3:0] OC_JAL     = 4'd3;
    localparam logic [3:0] OC_JALR    = 4'd4;
    localparam logic [3:0] OC_BRANCH  = 4'd5;
    localparam logic [3:0] OC_LOAD    = 4'd6;
    localparam logic [3:0] OC_STORE   = 4'd7;
    localparam logic [3:0] OC_OPIMM   = 4'd8;
    localparam logic [3:0] OC_OP      = 4'd9;
    localparam logic [3:0] OC_FENCE   = 4'd10;
    localparam logic [3:0] OC_SYSTEM  = 4'd11;
    localparam logic [3:0] OC_ILLEGAL = 4'd15;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    logic [3:0]         dec_opclass;
    logic signed [31:0] dec_imm;
    logic               dec_bad;

    logic               valid_q,     valid_d;
    logic [31:0]        instr_q,     instr_d;
    logic [31:0]        pc_q,        pc_d;
    logic [3:0]         opclass_q,   opclass_d;
    logic [4:0]         rd_q,        rd_d;
    logic [4:0]         rs1_q,       rs1_d;
    logic [4:0]         rs2_q,       rs2_d;
    logic signed [31:0] imm_q,       imm_d;
    logic               illegal_q,   illegal_d;
    logic               exc_start_q, exc_start_d;
    logic [31:0]        epc_q,       epc_d;
    logic [31:0]        cause_q,     cause_d;
    logic [1:0]         priv_q,      priv_d;
    logic               pend_q,      pend_d;
    logic [31:0]        pend_epc_q,  pend_epc_d;
    logic [31:0]        pend_cause_q, pend_cause_d;
    logic [1:0]         pend_priv_q, pend_priv_d;

    assign opcode = f2e_instr[6:0];
    assign funct3 = f2e_instr[14:12];
    assign funct7 = f2e_instr[31:25];

    assign imm_i = $signed({{20{f2e_instr[31]}}, f2e_instr[31:20]});
    assign imm_s = $signed({{20{f2e_instr[31]}}, f2e_instr[31:25], f2e_instr[11:7]});
    assign imm_b = $signed({{19{f2e_instr[31]}}, f2e_instr[31], f2e_instr[7],
                            f2e_instr[30:25], f2e_instr[11:8], 1'b0});
    assign imm_u = $signed({f2e_instr[31:12], 12'h000});
    assign imm_j = $signed({{11{f2e_instr[31]}}, f2e_instr[31], f2e_instr[19:12],
                            f2e_instr[20], f2e_instr[30:21], 1'b0});

    // Fetch stalls exactly when execute stalls; regfile reads track the
    // instruction that will sit in the decode register next cycle.
    assign e2f_ready   = x2d_ready;
    assign rf_rs1_addr = x2d_ready ? f2e_instr[19:15] : instr_q[19:15];
    assign rf_rs2_addr = x2d_ready ? f2e_instr[24:20] : instr_q[24:20];

    // Classify the incoming instruction and select its immediate format.
    always_comb begin
        dec_opclass = OC_ILLEGAL;
        dec_imm     = '0;
        dec_bad     = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec_opclass = OC_LUI;    dec_imm = imm_u; end
            OPC_AUIPC:  begin dec_opclass = OC_AUIPC;  dec_imm = imm_u; end
            OPC_JAL:    begin dec_opclass = OC_JAL;    dec_imm = imm_j; end
            OPC_JALR: begin
                dec_opclass = OC_JALR;
                dec_imm     = imm_i;
                dec_bad     = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_opclass = OC_BRANCH;
                dec_imm     = imm_b;
                dec_bad     = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                dec_opclass = OC_LOAD;
                dec_imm     = imm_i;
                dec_bad     = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec_opclass = OC_STORE;
                dec_imm     = imm_s;
                dec_bad     = (funct3 > 3'd2);
            end
            OPC_OPIMM: begin
                dec_opclass = OC_OPIMM;
                dec_imm     = imm_i;
                if (funct3 == 3'd1) begin
                    dec_bad = (funct7 != 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_OP: begin
                dec_opclass = OC_OP;
                if ((funct7 != 7'h00) && (funct7 != 7'h20) && (funct7 != 7'h01)) begin
                    dec_bad = 1'b1;
                end else if (funct7 == 7'h20) begin
                    dec_bad = (funct3 != 3'd0) && (funct3 != 3'd5);
                end
            end
            OPC_FENCE:  begin dec_opclass = OC_FENCE; end
            OPC_SYSTEM: begin dec_opclass = OC_SYSTEM; dec_imm = imm_i; end
            default:    begin dec_bad = 1'b1; end
        endcase
        if (dec_bad || (f2e_instr[1:0] != 2'b11) ||
            (f2e_instr == 32'h0000_0000) || (f2e_instr == 32'hffff_ffff)) begin
            dec_opclass = OC_ILLEGAL;
            dec_imm     = '0;
        end
    end

    // Next state of the decode register and the pending-exception slot.
    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        opclass_d    = opclass_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        illegal_d    = illegal_q;
        exc_start_d  = 1'b0;
        epc_d        = epc_q;
        cause_d      = cause_q;
        priv_d       = priv_q;
        pend_d       = pend_q;
        pend_epc_d   = pend_epc_q;
        pend_cause_d = pend_cause_q;
        pend_priv_d  = pend_priv_q;
        if (x2d_ready) begin
            pc_d = f2e_pc;
            if (x2d_kill || (f2e_instr == NOP_INSTR)) begin
                valid_d   = 1'b0;
                instr_d   = NOP_INSTR;
                opclass_d = OC_BUBBLE;
                rd_d      = '0;
                rs1_d     = '0;
                rs2_d     = '0;
                imm_d     = '0;
                illegal_d = 1'b0;
            end else begin
                valid_d   = 1'b1;
                instr_d   = f2e_instr;
                opclass_d = dec_opclass;
                rd_d      = f2e_instr[11:7];
                rs1_d     = f2e_instr[19:15];
                rs2_d     = f2e_instr[24:20];
                imm_d     = dec_imm;
                illegal_d = (dec_opclass == OC_ILLEGAL);
            end
            // A fresh pulse takes priority over one parked during a stall.
            if (f2e_exc_start) begin
                exc_start_d = 1'b1;
                epc_d       = f2e_epc;
                cause_d     = f2e_cause;
                priv_d      = f2e_exc_privilege;
            end else if (pend_q) begin
                exc_start_d = 1'b1;
                epc_d       = pend_epc_q;
                cause_d     = pend_cause_q;
                priv_d      = pend_priv_q;
            end else begin
                epc_d       = f2e_epc;
                cause_d     = f2e_cause;
                priv_d      = f2e_exc_privilege;
            end
            pend_d = 1'b0;
        end else if (f2e_exc_start) begin
            pend_d       = 1'b1;
            pend_epc_d   = f2e_epc;
            pend_cause_d = f2e_cause;
            pend_priv_d  = f2e_exc_privilege;
        end
    end

    // Decode register state with asynchronous reset to a bubble at RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= RESET_PC;
            opclass_q    <= OC_BUBBLE;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            illegal_q    <= 1'b0;
            exc_start_q  <= 1'b0;
            epc_q        <= '0;
            cause_q      <= '0;
            priv_q       <= '0;
            pend_q       <= 1'b0;
            pend_epc_q   <= '0;
            pend_cause_q <= '0;
            pend_priv_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            opclass_q    <= opclass_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            illegal_q    <= illegal_d;
            exc_start_q  <= exc_start_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            priv_q       <= priv_d;
            pend_q       <= pend_d;
            pend_epc_q   <= pend_epc_d;
            pend_cause_q <= pend_cause_d;
            pend_priv_q  <= pend_priv_d;
        end
    end

    assign d2e_valid         = valid_q;
    assign d2e_instr         = instr_q;
    assign d2e_pc            = pc_q;
    assign d2e_opclass       = opclass_q;
    assign d2e_rd            = rd_q;
    assign d2e_rs1           = rs1_q;
    assign d2e_rs2           = rs2_q;
    assign d2e_imm           = imm_q;
    assign d2e_illegal       = illegal_q;
    assign d2e_exc_start     = exc_start_q;
    assign d2e_epc           = epc_q;
    assign d2e_cause         = cause_q;
    assign d2e_exc_privilege = priv_q;

`ifdef ARMLEOCPU_DECODE_STATS_EN
    logic [31:0] stat_decoded_q;
    logic [31:0] stat_bubbles_q;
    logic [31:0] stat_illegal_q;

    // Count captured instructions, bubbles and illegal encodings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_decoded_q <= '0;
            stat_bubbles_q <= '0;
            stat_illegal_q <= '0;
        end else if (x2d_ready) begin
            if (valid_d) begin
                stat_decoded_q <= stat_decoded_q + 32'd1;
            end else begin
                stat_bubbles_q <= stat_bubbles_q + 32'd1;
            end
            if (illegal_d) begin
                stat_illegal_q <= stat_illegal_q + 32'd1;
            end
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_bubbles = stat_bubbles_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
